alu_cmd_master: RTL and testbench

Host-side command initiator for the UART ALU link. It takes one operand pair and opcode, frames them as three bytes (A, B, OP) into the UART transmitter, then waits for the single result byte from the UART receiver. It is the peer of `interface_alu`, used in loopback and board-to-board builds, and as the bench driver for the ALU path. Each wait is guarded by a timeout so a lost byte never hangs the link.

---
 rtl/alu_uart_pkg.sv | 23 ++
 rtl/alu_cmd_master_if.sv | 28 ++
 rtl/alu_cmd_master_wait_timer.sv | 20 ++
 rtl/alu_cmd_master.sv | 93 +++++++++
 tb/tb_alu_cmd_master.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: shared widths, ALU opcodes and command-master state encoding for the UART ALU link
package alu_uart_pkg;
  localparam int NB_DATA = 8;
  localparam int NB_OP = 6;
  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    WAIT_A,
    SEND_B,
    WAIT_B,
    SEND_OP,
    WAIT_OP,
    WAIT_RES
  } state_t;
endpackage

// File: rtl/alu_cmd_master_if.sv
// alu_cmd_master_if: command-side and UART-side signals of the ALU command master
// master modport is the command master's view; slave is the host/UART peer view.
interface alu_cmd_master_if #(
  parameter int NB_DATA = alu_uart_pkg::NB_DATA,
  parameter int NB_OP = alu_uart_pkg::NB_OP
);
  logic               i_start;
  logic [NB_DATA-1:0] i_dato_A;
  logic [NB_DATA-1:0] i_dato_B;
  logic [NB_OP-1:0]   i_OP;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid;
  logic               o_busy;
  logic               o_timeout;
  modport master (
    input  i_start, i_dato_A, i_dato_B, i_OP, i_tx_done, i_rx_data, i_rx_done,
    output o_tx_data, o_tx_start, o_result, o_result_valid, o_busy, o_timeout
  );
  modport slave (
    output i_start, i_dato_A, i_dato_B, i_OP, i_tx_done, i_rx_data, i_rx_done,
    input  o_tx_data, o_tx_start, o_result, o_result_valid, o_busy, o_timeout
  );
endinterface

// File: rtl/alu_cmd_master_wait_timer.sv
// wait_timer: cycle counter shared by all wait states; expires on the last allowed cycle
// Ports: i_clock, i_reset (async, active low), i_clear (restart at 0, wins over enable),
//   i_enable (count this cycle), o_expired (count has reached TIMEOUT_CYCLES-1).
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES);
  logic [NB_CNT-1:0] count;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) count <= '0;
    else if (i_clear) count <= '0;
    else if (i_enable) count <= count + 1'b1;
  assign o_expired = count == NB_CNT'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/alu_cmd_master.sv
// alu_cmd_master: frames A, B, OP into the UART transmitter and waits for the ALU result byte
// Ports: i_clock, i_reset (async, active low); bus (master modport) carries
//   command side: i_start, i_dato_A, i_dato_B, i_OP in; o_result, o_result_valid, o_busy, o_timeout out
//   UART side:    o_tx_data, o_tx_start out; i_tx_done, i_rx_data, i_rx_done in
module alu_cmd_master
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA = alu_uart_pkg::NB_DATA,
  parameter int NB_OP = alu_uart_pkg::NB_OP,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic i_clock,
  input logic i_reset,
  alu_cmd_master_if.master bus
);
  state_t state;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0] op_q;
  logic [NB_DATA-1:0] tx_data;
  logic [NB_DATA-1:0] result;
  logic tx_start;
  logic result_valid;
  logic timeout;
  logic in_wait;
  logic done_now;
  logic expired;
  assign in_wait = state inside {WAIT_A, WAIT_B, WAIT_OP, WAIT_RES};
  // Only the done pulse that belongs to the current wait counts; everything else is ignored.
  assign done_now = state == WAIT_RES ? bus.i_rx_done : in_wait & bus.i_tx_done;
  // Clearing on a done pulse restarts the count for a wait-to-wait hop (WAIT_OP -> WAIT_RES).
  wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (!in_wait || done_now),
    .i_enable (in_wait),
    .o_expired(expired)
  );
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state <= IDLE;
      b_q <= '0;
      op_q <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      result_valid <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          b_q <= bus.i_dato_B;
          op_q <= bus.i_OP;
          tx_data <= bus.i_dato_A;
          tx_start <= 1'b1;
          state <= SEND_A;
        end
        SEND_A: state <= WAIT_A;
        WAIT_A: if (done_now) begin
          tx_data <= b_q;
          tx_start <= 1'b1;
          state <= SEND_B;
        end
        SEND_B: state <= WAIT_B;
        WAIT_B: if (done_now) begin
          tx_data <= NB_DATA'(op_q);
          tx_start <= 1'b1;
          state <= SEND_OP;
        end
        SEND_OP: state <= WAIT_OP;
        WAIT_OP: if (done_now) state <= WAIT_RES;
        WAIT_RES: if (done_now) begin
          result <= bus.i_rx_data;
          result_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A done pulse on the last allowed cycle still wins over expiry.
      if (in_wait && !done_now && expired) begin
        timeout <= 1'b1;
        state <= IDLE;
      end
    end
  assign bus.o_tx_data = tx_data;
  assign bus.o_tx_start = tx_start;
  assign bus.o_result = result;
  assign bus.o_result_valid = result_valid;
  assign bus.o_timeout = timeout;
  assign bus.o_busy = state != IDLE;
endmodule

// File: tb/tb_alu_cmd_master.sv
// tb_alu_cmd_master: directed scenarios for the UART ALU command master with a 16-cycle timeout
module tb_alu_cmd_master;
  import alu_uart_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [7:0] tx_log[$];
  int rv_cnt = 0;
  int to_cnt = 0;
  int both_cnt = 0;
  alu_cmd_master_if bus ();
  alu_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #1;
    if (bus.o_tx_start === 1'b1) tx_log.push_back(bus.o_tx_data);
    if (bus.o_result_valid === 1'b1) rv_cnt++;
    if (bus.o_timeout === 1'b1) to_cnt++;
    if (bus.o_result_valid === 1'b1 && bus.o_timeout === 1'b1) both_cnt++;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic start_frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    bus.i_dato_A = a;
    bus.i_dato_B = b;
    bus.i_OP = op;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_tx(output int n);
    n = 0;
    while (bus.o_tx_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic tx_ack(input int d);
    repeat (d) @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask
  task automatic rx_byte(input logic [7:0] d);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask
  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else pass_cnt++;
    chk_cnt++; if (bus.o_tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", bus.o_tx_start); else pass_cnt++;
    chk_cnt++; if (bus.o_tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.o_tx_data); else pass_cnt++;
    chk_cnt++; if (bus.o_result !== 8'h00) $display("FAIL reset_result: got %h want 00", bus.o_result); else pass_cnt++;
    chk_cnt++; if (bus.o_result_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_result_valid); else pass_cnt++;
    chk_cnt++; if (bus.o_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.o_timeout); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_nominal;
    int n;
    tx_log.delete();
    rv_cnt = 0;
    start_frame(8'hF0, 8'h0F, 6'b100100);
    wait_tx(n);
    chk_cnt++; if (n !== 0) $display("FAIL nom_start_latency: got %0d want 0", n); else pass_cnt++;
    tx_ack(10);
    wait_tx(n);
    chk_cnt++; if (n !== 0) $display("FAIL nom_next_byte_latency: got %0d want 0", n); else pass_cnt++;
    tx_ack(10);
    wait_tx(n);
    tx_ack(10);
    repeat (3) @(negedge clk);
    chk_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL nom_busy_wait_res: got %b want 1", bus.o_busy); else pass_cnt++;
    rx_byte(8'hFF);
    chk_cnt++; if (bus.o_result !== 8'hFF) $display("FAIL nom_result: got %h want ff", bus.o_result); else pass_cnt++;
    chk_cnt++; if (bus.o_result_valid !== 1'b1) $display("FAIL nom_valid: got %b want 1", bus.o_result_valid); else pass_cnt++;
    chk_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL nom_busy_done: got %b want 0", bus.o_busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.o_result_valid !== 1'b0) $display("FAIL nom_valid_pulse: got %b want 0", bus.o_result_valid); else pass_cnt++;
    chk_cnt++; if (tx_log.size() !== 3) $display("FAIL nom_tx_count: got %0d want 3", tx_log.size()); else pass_cnt++;
    if (tx_log.size() == 3) begin
      chk_cnt++; if (tx_log[0] !== 8'hF0) $display("FAIL nom_byte_a: got %h want f0", tx_log[0]); else pass_cnt++;
      chk_cnt++; if (tx_log[1] !== 8'h0F) $display("FAIL nom_byte_b: got %h want 0f", tx_log[1]); else pass_cnt++;
      chk_cnt++; if (tx_log[2] !== 8'h24) $display("FAIL nom_byte_op: got %h want 24", tx_log[2]); else pass_cnt++;
    end
    chk_cnt++; if (rv_cnt !== 1) $display("FAIL nom_valid_count: got %0d want 1", rv_cnt); else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    int n;
    logic [7:0] exp[6] = '{8'h05, 8'h06, 8'h22, 8'h01, 8'h02, 8'h20};
    tx_log.delete();
    rv_cnt = 0;
    start_frame(8'h05, 8'h06, OP_SUB);
    wait_tx(n);
    @(negedge clk);
    start_frame(8'h01, 8'h02, OP_ADD);
    tx_ack(3);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    repeat (2) @(negedge clk);
    rx_byte(8'hFF);
    chk_cnt++; if (bus.o_result_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b want 1", bus.o_result_valid); else pass_cnt++;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk_cnt++; if (bus.o_tx_start !== 1'b1) $display("FAIL b2b_restart: got %b want 1", bus.o_tx_start); else pass_cnt++;
    chk_cnt++; if (bus.o_tx_data !== 8'h01) $display("FAIL b2b_restart_data: got %h want 01", bus.o_tx_data); else pass_cnt++;
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    rx_byte(8'h5A);
    chk_cnt++; if (bus.o_result !== 8'h5A) $display("FAIL b2b_second_result: got %h want 5a", bus.o_result); else pass_cnt++;
    chk_cnt++; if (tx_log.size() !== 6) $display("FAIL b2b_tx_count: got %0d want 6", tx_log.size()); else pass_cnt++;
    if (tx_log.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk_cnt++; if (tx_log[i] !== exp[i]) $display("FAIL b2b_byte_%0d: got %h want %h", i, tx_log[i], exp[i]); else pass_cnt++;
      end
    chk_cnt++; if (rv_cnt !== 2) $display("FAIL b2b_valid_count: got %0d want 2", rv_cnt); else pass_cnt++;
  endtask
  task automatic test_stray_rx;
    int n;
    rv_cnt = 0;
    start_frame(8'h07, 8'h08, OP_ADD);
    wait_tx(n);
    @(negedge clk);
    rx_byte(8'hAA);
    chk_cnt++; if (bus.o_result !== 8'h5A) $display("FAIL stray_result_held: got %h want 5a", bus.o_result); else pass_cnt++;
    chk_cnt++; if (bus.o_result_valid !== 1'b0) $display("FAIL stray_no_valid: got %b want 0", bus.o_result_valid); else pass_cnt++;
    chk_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL stray_still_busy: got %b want 1", bus.o_busy); else pass_cnt++;
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    rx_byte(8'h03);
    chk_cnt++; if (bus.o_result !== 8'h03) $display("FAIL stray_good_result: got %h want 03", bus.o_result); else pass_cnt++;
    chk_cnt++; if (rv_cnt !== 1) $display("FAIL stray_valid_count: got %0d want 1", rv_cnt); else pass_cnt++;
  endtask
  task automatic test_op_width;
    int n;
    start_frame(8'h00, 8'h00, 6'b111111);
    wait_tx(n);
    tx_ack(1);
    wait_tx(n);
    tx_ack(1);
    wait_tx(n);
    chk_cnt++; if (bus.o_tx_data !== 8'h3F) $display("FAIL opw_byte: got %h want 3f", bus.o_tx_data); else pass_cnt++;
    tx_ack(1);
    rx_byte(8'hC3);
    chk_cnt++; if (bus.o_result !== 8'hC3) $display("FAIL opw_result: got %h want c3", bus.o_result); else pass_cnt++;
  endtask
  task automatic test_timeout_tx;
    int n;
    tx_log.delete();
    to_cnt = 0;
    start_frame(8'h11, 8'h22, OP_XOR);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    repeat (16) @(negedge clk);
    chk_cnt++; if (bus.o_timeout !== 1'b0) $display("FAIL to_early: got %b want 0", bus.o_timeout); else pass_cnt++;
    chk_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL to_busy_before: got %b want 1", bus.o_busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.o_timeout !== 1'b1) $display("FAIL to_fire: got %b want 1", bus.o_timeout); else pass_cnt++;
    chk_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL to_idle: got %b want 0", bus.o_busy); else pass_cnt++;
    chk_cnt++; if (bus.o_result !== 8'hC3) $display("FAIL to_result_held: got %h want c3", bus.o_result); else pass_cnt++;
    chk_cnt++; if (bus.o_result_valid !== 1'b0) $display("FAIL to_no_valid: got %b want 0", bus.o_result_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.o_timeout !== 1'b0) $display("FAIL to_pulse: got %b want 0", bus.o_timeout); else pass_cnt++;
    chk_cnt++; if (to_cnt !== 1) $display("FAIL to_count: got %0d want 1", to_cnt); else pass_cnt++;
    chk_cnt++; if (tx_log.size() !== 2) $display("FAIL to_tx_count: got %0d want 2", tx_log.size()); else pass_cnt++;
  endtask
  task automatic test_timeout_rx_edge;
    int n;
    to_cnt = 0;
    start_frame(8'h33, 8'h44, OP_OR);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    repeat (15) @(negedge clk);
    chk_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL edge_busy: got %b want 1", bus.o_busy); else pass_cnt++;
    rx_byte(8'h77);
    chk_cnt++; if (bus.o_result_valid !== 1'b1) $display("FAIL edge_valid: got %b want 1", bus.o_result_valid); else pass_cnt++;
    chk_cnt++; if (bus.o_result !== 8'h77) $display("FAIL edge_result: got %h want 77", bus.o_result); else pass_cnt++;
    chk_cnt++; if (bus.o_timeout !== 1'b0) $display("FAIL edge_no_timeout: got %b want 0", bus.o_timeout); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (to_cnt !== 0) $display("FAIL edge_timeout_count: got %0d want 0", to_cnt); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    int n;
    tx_log.delete();
    start_frame(8'h55, 8'h66, OP_AND);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    tx_ack(2);
    wait_tx(n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", bus.o_busy); else pass_cnt++;
    chk_cnt++; if (bus.o_tx_data !== 8'h00) $display("FAIL rmid_tx_data: got %h want 00", bus.o_tx_data); else pass_cnt++;
    chk_cnt++; if (bus.o_result !== 8'h00) $display("FAIL rmid_result: got %h want 00", bus.o_result); else pass_cnt++;
    chk_cnt++; if (bus.o_tx_start !== 1'b0) $display("FAIL rmid_tx_start: got %b want 0", bus.o_tx_start); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    repeat (20) @(negedge clk);
    chk_cnt++; if (tx_log.size() !== 3) $display("FAIL rmid_no_tx: got %0d want 3", tx_log.size()); else pass_cnt++;
    chk_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rmid_idle: got %b want 0", bus.o_busy); else pass_cnt++;
    chk_cnt++; if (both_cnt !== 0) $display("FAIL valid_timeout_overlap: got %0d want 0", both_cnt); else pass_cnt++;
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_dato_A = '0;
    bus.i_dato_B = '0;
    bus.i_OP = '0;
    bus.i_tx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_stray_rx();
    test_op_width();
    test_timeout_tx();
    test_timeout_rx_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
